i2s_tdm_core: RTL

Parametrised multi-channel TDM serial audio engine, the next-generation core behind the APB4 I2S peripheral. It carries SLOT_NUM time slots per frame, up to 16, each SLOT_WIDTH bits wide, on one serial data pair. A per-slot enable mask selects active slots, and transmit/receive words move through valid/ready streams tagged with their slot index. Serial clock and frame sync come in as asynchronous pins; the register block, clock generator and FIFOs sit outside.

---
 rtl/i2s_tdm_pkg.sv | 35 +++
 rtl/i2s_tdm_sync.sv | 48 ++++
 rtl/i2s_tdm_core.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tdm_pkg.sv
// i2s_tdm_pkg: shared types and constants for the TDM serial audio core.
//   state_t      FSM state encoding (IDLE, WAIT_FS, ACTIVE)
//   DTL_*        data-length encodings carried on dtl_i
//   dtl_bits()   maps a dtl code to its bit count (8/16/24/32)
//   SYNC_STAGES  depth of the pin synchronisers
//   SLOT_*_MIN/MAX  legal limits for SLOT_NUM and SLOT_WIDTH
package i2s_tdm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_FS = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam logic [1:0] DTL_8  = 2'd0;
  localparam logic [1:0] DTL_16 = 2'd1;
  localparam logic [1:0] DTL_24 = 2'd2;
  localparam logic [1:0] DTL_32 = 2'd3;

  localparam int SYNC_STAGES    = 2;
  localparam int SLOT_NUM_MIN   = 2;
  localparam int SLOT_NUM_MAX   = 16;
  localparam int SLOT_WIDTH_MIN = 16;
  localparam int SLOT_WIDTH_MAX = 32;

  function automatic logic [5:0] dtl_bits(input logic [1:0] dtl);
    case (dtl)
      DTL_8:   dtl_bits = 6'd8;
      DTL_16:  dtl_bits = 6'd16;
      DTL_24:  dtl_bits = 6'd24;
      default: dtl_bits = 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/i2s_tdm_sync.sv
// i2s_tdm_sync: synchronisers and sck edge detect for the serial pins.
//   clk, rst_n      system clock, async active-low reset
//   sck, fs, sd     asynchronous serial pins
//   sck_rise        one-clk pulse, sck rising (sample) edge
//   sck_fall        one-clk pulse, sck falling (drive) edge
//   fs_s, sd_s      synchronised fs/sd, aligned with the edge pulses
// Pin to edge pulse is SYNC_STAGES + 1 clk.
module i2s_tdm_sync
  import i2s_tdm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic fs,
  input  logic sd,
  output logic sck_rise,
  output logic sck_fall,
  output logic fs_s,
  output logic sd_s
);

  logic [SYNC_STAGES-1:0] sck_ff, fs_ff, sd_ff;
  logic                   sck_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_ff   <= '0;
      fs_ff    <= '0;
      sd_ff    <= '0;
      sck_prev <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      fs_s     <= 1'b0;
      sd_s     <= 1'b0;
    end else begin
      sck_ff   <= {sck_ff[SYNC_STAGES-2:0], sck};
      fs_ff    <= {fs_ff[SYNC_STAGES-2:0], fs};
      sd_ff    <= {sd_ff[SYNC_STAGES-2:0], sd};
      sck_prev <= sck_ff[SYNC_STAGES-1];
      sck_rise <= sck_ff[SYNC_STAGES-1] & ~sck_prev;
      sck_fall <= ~sck_ff[SYNC_STAGES-1] & sck_prev;
      // fs/sd get the same extra stage so they line up with the edge pulses
      fs_s     <= fs_ff[SYNC_STAGES-1];
      sd_s     <= sd_ff[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/i2s_tdm_core.sv
// i2s_tdm_core: multi-slot TDM serial audio engine (TX and RX on one pin pair).
//   clk_i, rst_n_i            system clock, async active-low reset
//   en_i, lsb_i, dly_i, dtl_i  enable, bit order, one-bit delay, data length
//   slot_en_i                  active-slot mask
//   clr_i                      clears sticky flags
//   tx_valid_i/tx_ready_o/tx_data_i           transmit stream
//   rx_valid_o/rx_ready_i/rx_data_o/rx_slot_o receive stream
//   sck_i, fs_i, sd_i, sd_o    serial pins
//   busy_o, urun_o, orun_o, frm_err_o         status
// Optional macro I2S_TDM_LOOPBACK_EN adds lpbk_i (RX takes sd_o instead of sd_i).
//
// Frame timing reference: the sck rising edge at which fs is first seen high.
// With dly_i=0, bit 0 of slot 0 is driven on the next falling edge; with
// dly_i=1 one lead bit (driven 0, not sampled) comes first.
//
// state   | meaning
// IDLE    | core disabled, counters cleared, sd_o low
// WAIT_FS | enabled, waiting for an fs rising edge
// ACTIVE  | frame in progress, bits driven on fall, sampled on rise
module i2s_tdm_core
  import i2s_tdm_pkg::*;
#(
  parameter int SLOT_NUM   = 8,
  parameter int SLOT_WIDTH = 32,
  parameter int SLOT_IDX_W = $clog2(SLOT_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  lsb_i,
  input  logic                  dly_i,
  input  logic [1:0]            dtl_i,
  input  logic [SLOT_NUM-1:0]   slot_en_i,
  input  logic                  clr_i,
`ifdef I2S_TDM_LOOPBACK_EN
  input  logic                  lpbk_i,
`endif
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [31:0]           tx_data_i,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [31:0]           rx_data_o,
  output logic [SLOT_IDX_W-1:0] rx_slot_o,
  input  logic                  sck_i,
  input  logic                  fs_i,
  input  logic                  sd_i,
  output logic                  sd_o,
  output logic                  busy_o,
  output logic                  urun_o,
  output logic                  orun_o,
  output logic                  frm_err_o
);

  // Out-of-range parameters are pulled back into the legal window.
  localparam int SN = (SLOT_NUM > SLOT_NUM_MAX) ? SLOT_NUM_MAX :
                      (SLOT_NUM < SLOT_NUM_MIN) ? SLOT_NUM_MIN : SLOT_NUM;
  localparam int SW = (SLOT_WIDTH > SLOT_WIDTH_MAX) ? SLOT_WIDTH_MAX :
                      (SLOT_WIDTH < SLOT_WIDTH_MIN) ? SLOT_WIDTH_MIN : SLOT_WIDTH;
  localparam logic [4:0]            BIT_LAST  = 5'(SW - 1);
  localparam logic [SLOT_IDX_W-1:0] SLOT_LAST = SLOT_IDX_W'(SN - 1);

  state_t                state;
  logic [4:0]            bit_cnt;
  logic [SLOT_IDX_W-1:0] slot_cnt;
  logic                  lead;
  logic                  fs_prev;
  logic [31:0]           tx_word, rx_acc;

  logic sck_rise, sck_fall, fs_s, sd_s;

  i2s_tdm_sync u_sync (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .sck      (sck_i),
    .fs       (fs_i),
    .sd       (sd_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .fs_s     (fs_s),
    .sd_s     (sd_s)
  );

  logic [5:0]  n_bits;
  logic        in_field, first_bit, last_bit, last_slot, slot_on;
  logic [4:0]  bit_idx;
  logic        live, drive, sample, fs_edge, pop_slot, frm_set;
  logic [31:0] tx_src, rx_next;
  logic        tx_bit, rx_bit;

  always_comb begin
    n_bits    = (dtl_bits(dtl_i) > 6'(SW)) ? 6'(SW) : dtl_bits(dtl_i);
    in_field  = {1'b0, bit_cnt} < n_bits;
    first_bit = (bit_cnt == 5'd0);
    last_bit  = (bit_cnt == BIT_LAST);
    last_slot = (slot_cnt == SLOT_LAST);
    slot_on   = slot_en_i[slot_cnt];
    // LSB-first walks the data field upward from its bottom; the field itself
    // always sits at the top of the 32-bit word.
    bit_idx   = lsb_i ? 5'(6'd32 - n_bits + {1'b0, bit_cnt}) : (5'd31 - bit_cnt);

    live      = (state == ACTIVE) && en_i;
    drive     = live && sck_fall && !lead;
    sample    = live && sck_rise;
    fs_edge   = sck_rise && fs_s && !fs_prev;
    pop_slot  = drive && first_bit && slot_on;
    // an fs edge on the final bit of the frame is a legal back-to-back start
    frm_set   = sample && fs_edge && !(!lead && last_bit && last_slot);

    tx_ready_o = pop_slot && tx_valid_i;
    tx_src     = first_bit ? ((pop_slot && tx_valid_i) ? tx_data_i : 32'd0) : tx_word;
    tx_bit     = in_field && tx_src[bit_idx];

`ifdef I2S_TDM_LOOPBACK_EN
    rx_bit = lpbk_i ? sd_o : sd_s;
`else
    rx_bit = sd_s;
`endif
    rx_next = first_bit ? 32'd0 : rx_acc;
    if (in_field) rx_next[bit_idx] = rx_bit;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      lead       <= 1'b0;
      fs_prev    <= 1'b0;
      tx_word    <= '0;
      rx_acc     <= '0;
      sd_o       <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      rx_slot_o  <= '0;
      busy_o     <= 1'b0;
      urun_o     <= 1'b0;
      orun_o     <= 1'b0;
      frm_err_o  <= 1'b0;
    end else begin
      if (sck_rise) fs_prev <= fs_s;
      rx_valid_o <= 1'b0;
      busy_o     <= (state == ACTIVE);
      urun_o     <= (urun_o & ~clr_i) | (pop_slot & ~tx_valid_i);
      orun_o     <= (orun_o & ~clr_i) | (rx_valid_o & ~rx_ready_i);
      frm_err_o  <= (frm_err_o & ~clr_i) | frm_set;

      if (!en_i) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        slot_cnt <= '0;
        lead     <= 1'b0;
        sd_o     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sd_o  <= 1'b0;
            state <= WAIT_FS;
          end
          WAIT_FS: begin
            if (sck_fall) sd_o <= 1'b0;
            if (fs_edge) begin
              state    <= ACTIVE;
              bit_cnt  <= '0;
              slot_cnt <= '0;
              lead     <= dly_i;
            end
          end
          ACTIVE: begin
            if (sck_fall) sd_o <= drive ? tx_bit : 1'b0;
            if (drive && first_bit) tx_word <= tx_src;
            if (sck_rise) begin
              if (frm_set) begin
                bit_cnt  <= '0;
                slot_cnt <= '0;
                lead     <= dly_i;
              end else if (lead) begin
                lead <= 1'b0;
              end else begin
                rx_acc <= rx_next;
                if (last_bit) begin
                  if (slot_on) begin
                    rx_valid_o <= 1'b1;
                    rx_data_o  <= rx_next;
                    rx_slot_o  <= slot_cnt;
                  end
                  bit_cnt <= '0;
                  if (last_slot) begin
                    slot_cnt <= '0;
                    if (fs_edge) lead  <= dly_i;
                    else         state <= WAIT_FS;
                  end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
